// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and width helpers for the convolution MAC.
//   clog2     - ceiling log2 (0 for inputs of 0 or 1)
//   conv_ow   - accumulator/result width for a given KERNEL, N, M, CH_IN
//   level_w   - adder-tree level width: base product width plus one bit per level
//   node_cnt  - number of nodes at a given tree level for a given leaf count
package conv_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int conv_ow(input int kernel, input int n, input int m, input int ch_in);
    return n + m + clog2(kernel * kernel) + clog2(ch_in) + 1;
  endfunction

  function automatic int level_w(input int base, input int level);
    return base + level;
  endfunction

  function automatic int node_cnt(input int leaves, input int level);
    return (leaves + (1 << level) - 1) >> level;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: signed pairwise reduction tree with a valid bit per level.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        synchronous flush of all level valid bits
//   in_vld     leaves are valid this cycle
//   leaves     LEAVES signed values of IW bits, element i at [i*IW +: IW]
//   out_vld    sum is valid
//   sum        signed total, IW + clog2(LEAVES) bits
// Level data registers only load when the level below is valid, so gaps in
// the input stream leave the data in place and only the valid bits move.
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int LEAVES = 9,
  parameter int IW = 16,
  parameter bit REG_LEVEL = 1'b1,
  localparam int LEVELS = clog2(LEAVES),
  localparam int OUTW = IW + LEVELS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_vld,
  input  logic [LEAVES*IW-1:0] leaves,
  output logic                 out_vld,
  output logic [OUTW-1:0]      sum
);

  for (genvar j = 0; j <= LEVELS; j++) begin : g_lvl
    localparam int CNT = node_cnt(LEAVES, j);
    localparam int W = level_w(IW, j);
    logic [CNT*W-1:0] node;
    logic             vld;

    if (j == 0) begin : g_leaf
      assign node = leaves;
      assign vld  = in_vld;
    end else begin : g_add
      localparam int PW = W - 1;
      // Previous level zero-padded to an even count: an unpaired node is
      // added to zero, which is the same as passing it through sign-extended.
      logic [2*CNT*PW-1:0] prev;
      logic [CNT*W-1:0]    node_next;

      assign prev = (2*CNT*PW)'(g_lvl[j-1].node);

      for (genvar i = 0; i < CNT; i++) begin : g_pair
        assign node_next[i*W +: W] = W'($signed(prev[2*i*PW +: PW]))
                                   + W'($signed(prev[(2*i+1)*PW +: PW]));
      end

      if (REG_LEVEL) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            node <= '0;
            vld  <= 1'b0;
          end else begin
            vld <= g_lvl[j-1].vld & ~clr;
            if (g_lvl[j-1].vld) node <= node_next;
          end
        end
      end else begin : g_comb
        assign node = node_next;
        assign vld  = g_lvl[j-1].vld;
      end
    end
  end

  assign sum     = g_lvl[LEVELS].node;
  assign out_vld = g_lvl[LEVELS].vld;

endmodule

// File: rtl/conv_mac_acc.sv
// conv_mac_acc: signed KERNELxKERNEL convolution MAC with channel accumulation
// and bias. One result per CH_IN input beats, latency clog2(KERNEL^2)+2.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous flush of valid bits, channel count and en_out
//   en_in       input beat valid
//   data2conv   window, element i at [i*N +: N]
//   w           weights, element i at [i*M +: M]
//   bias        signed bias, taken on the beat that starts a pixel
//   d_out       signed result, held between pulses
//   en_out      one-cycle pulse marking a new d_out
// Build option: define CONV_RELU_EN to clamp negative results to 0 at d_out
// (the accumulator itself stays unclamped).
module conv_mac_acc
  import conv_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int N = 8,
  parameter int M = 8,
  parameter int CH_IN = 4,
  localparam int OW = conv_ow(KERNEL, N, M, CH_IN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en_in,
  input  logic [KERNEL*KERNEL*N-1:0] data2conv,
  input  logic [KERNEL*KERNEL*M-1:0] w,
  input  logic [OW-1:0]              bias,
  output logic [OW-1:0]              d_out,
  output logic                       en_out
);

  localparam int TAPS = KERNEL * KERNEL;
  localparam int PW = N + M;
  localparam int TW = PW + clog2(TAPS);
  localparam int CW = (CH_IN > 1) ? clog2(CH_IN) : 1;

  logic [TAPS*PW-1:0] prod_next;
  logic [TAPS*PW-1:0] prod;
  logic               prod_vld;
  logic [TW-1:0]      tree_sum;
  logic               tree_vld;
  logic signed [OW-1:0] acc;
  logic signed [OW-1:0] acc_next;
  logic signed [OW-1:0] res;
  logic [OW-1:0]      res_out;
  logic               res_vld;
  logic [CW-1:0]      ch_cnt;
  logic               last;
  logic               take;

  for (genvar i = 0; i < TAPS; i++) begin : g_mul
    logic signed [PW-1:0] p;
    assign p = $signed(w[i*M +: M]) * $signed(data2conv[i*N +: N]);
    assign prod_next[i*PW +: PW] = p;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= en_in & ~clr;
      if (en_in) prod <= prod_next;
    end
  end

  conv_adder_tree #(
    .LEAVES   (TAPS),
    .IW       (PW),
    .REG_LEVEL(1'b1)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .in_vld (prod_vld),
    .leaves (prod),
    .out_vld(tree_vld),
    .sum    (tree_sum)
  );

  assign last = (ch_cnt == CW'(CH_IN - 1));
  assign take = tree_vld & ~clr;

  always_comb begin
    acc_next = acc + OW'($signed(tree_sum));
    if (ch_cnt == '0) acc_next = OW'($signed(tree_sum)) + $signed(bias);
  end

`ifdef CONV_RELU_EN
  assign res_out = res[OW-1] ? '0 : res;
`else
  assign res_out = res;
`endif

  // Result is registered once more before d_out so the clamp sits off the
  // accumulator's add path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      ch_cnt  <= '0;
      res     <= '0;
      res_vld <= 1'b0;
      d_out   <= '0;
      en_out  <= 1'b0;
    end else begin
      if (clr) begin
        ch_cnt <= '0;
      end else if (tree_vld) begin
        acc    <= acc_next;
        ch_cnt <= last ? '0 : ch_cnt + 1'b1;
      end
      res_vld <= take & last;
      if (take & last) res <= acc_next;
      en_out <= res_vld & ~clr;
      if (res_vld & ~clr) d_out <= res_out;
    end
  end

endmodule

// File: tb/tb_conv_mac_acc.sv
// Directed self-checking bench for conv_mac_acc using three instances:
// KERNEL=3/CH_IN=1, KERNEL=3/CH_IN=4 and KERNEL=1/CH_IN=2.
module tb_conv_mac_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // A: KERNEL=3, CH_IN=1, OW=21
  logic        a_clr, a_en, a_eo;
  logic [71:0] a_data, a_w;
  logic [20:0] a_bias, a_dout;
  // B: KERNEL=3, CH_IN=4, OW=23
  logic        b_clr, b_en, b_eo;
  logic [71:0] b_data, b_w;
  logic [22:0] b_bias, b_dout;
  // C: KERNEL=1, CH_IN=2, OW=18
  logic        c_clr, c_en, c_eo;
  logic [7:0]  c_data, c_w;
  logic [17:0] c_bias, c_dout;

  conv_mac_acc #(.KERNEL(3), .N(8), .M(8), .CH_IN(1)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .en_in(a_en), .data2conv(a_data),
    .w(a_w), .bias(a_bias), .d_out(a_dout), .en_out(a_eo));

  conv_mac_acc #(.KERNEL(3), .N(8), .M(8), .CH_IN(4)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .en_in(b_en), .data2conv(b_data),
    .w(b_w), .bias(b_bias), .d_out(b_dout), .en_out(b_eo));

  conv_mac_acc #(.KERNEL(1), .N(8), .M(8), .CH_IN(2)) u_c (
    .clk(clk), .rst(rst), .clr(c_clr), .en_in(c_en), .data2conv(c_data),
    .w(c_w), .bias(c_bias), .d_out(c_dout), .en_out(c_eo));

`ifdef CONV_RELU_EN
  localparam int B_SIGNED_EXP = 0;
  localparam int C_EXP = 0;
`else
  localparam int B_SIGNED_EXP = -585216;
  localparam int C_EXP = -30;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int a_pulses = 0, b_pulses = 0, c_pulses = 0;
  int b_b2b = 0;
  logic b_eo_prev = 1'b0;

  always @(negedge clk) begin
    if (a_eo) a_pulses++;
    if (b_eo) b_pulses++;
    if (c_eo) c_pulses++;
    if (b_eo && b_eo_prev) b_b2b++;
    b_eo_prev = b_eo;
  end

  // Latency from the last beat's sampling edge to the first en_out seen.
  task automatic wait_a(output int lat);
    lat = 0;
    while (a_eo !== 1'b1 && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
  endtask
  task automatic wait_b(output int lat);
    lat = 0;
    while (b_eo !== 1'b1 && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
  endtask
  task automatic wait_c(output int lat);
    lat = 0;
    while (c_eo !== 1'b1 && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_clr = 0; a_en = 0; a_data = '0; a_w = '0; a_bias = '0;
    b_clr = 0; b_en = 0; b_data = '0; b_w = '0; b_bias = '0;
    c_clr = 0; c_en = 0; c_data = '0; c_w = '0; c_bias = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_eo !== 1'b0) begin n_fail++; $display("FAIL reset_a_en_out: got %b expected 0", a_eo); end
    n_checks++; if (a_dout !== 21'd0) begin n_fail++; $display("FAIL reset_a_d_out: got %0d expected 0", a_dout); end
    n_checks++; if (b_eo !== 1'b0) begin n_fail++; $display("FAIL reset_b_en_out: got %b expected 0", b_eo); end
    n_checks++; if (b_dout !== 23'd0) begin n_fail++; $display("FAIL reset_b_d_out: got %0d expected 0", b_dout); end
    n_checks++; if (c_eo !== 1'b0) begin n_fail++; $display("FAIL reset_c_en_out: got %b expected 0", c_eo); end
    n_checks++; if (c_dout !== 18'd0) begin n_fail++; $display("FAIL reset_c_d_out: got %0d expected 0", c_dout); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, p0;
    a_data = {9{8'd1}}; a_w = {9{8'd1}}; a_bias = '0;
    p0 = a_pulses;
    a_en = 1; @(posedge clk); @(negedge clk); a_en = 0;
    wait_a(lat);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency: got %0d expected 6", lat); end
    n_checks++; if (a_dout !== 21'd9) begin n_fail++; $display("FAIL basic_d_out: got %0d expected 9", $signed(a_dout)); end
    repeat (8) @(negedge clk);
    n_checks++; if (a_pulses - p0 !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 1", a_pulses - p0); end
  endtask

  task automatic test_bias_neg();
    int lat;
    a_data = {9{8'd1}}; a_w = {9{8'd1}}; a_bias = 21'(-5);
    a_en = 1; @(posedge clk); @(negedge clk); a_en = 0;
    wait_a(lat);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL bias_latency: got %0d expected 6", lat); end
    n_checks++; if (a_dout !== 21'd4) begin n_fail++; $display("FAIL bias_d_out: got %0d expected 4", $signed(a_dout)); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_signed_extreme();
    int lat, p0;
    b_data = {9{8'h80}}; b_w = {9{8'h7F}}; b_bias = '0;
    p0 = b_pulses;
    b_en = 1; repeat (4) @(posedge clk); @(negedge clk); b_en = 0;
    wait_b(lat);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL signed_latency: got %0d expected 6", lat); end
    n_checks++; if (b_dout !== 23'(B_SIGNED_EXP)) begin n_fail++; $display("FAIL signed_d_out: got %0d expected %0d", $signed(b_dout), B_SIGNED_EXP); end
    repeat (10) @(negedge clk);
    n_checks++; if (b_pulses - p0 !== 1) begin n_fail++; $display("FAIL signed_pulses: got %0d expected 1", b_pulses - p0); end
  endtask

  task automatic test_gaps();
    int lat, p0;
    int gaps[3];
    gaps = '{0, 3, 1};
    b_data = {9{8'd2}}; b_w = {9{8'd3}}; b_bias = 23'd10;
    p0 = b_pulses;
    b_en = 1; @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (gaps[k] > 0) begin
        b_en = 0;
        repeat (gaps[k]) @(negedge clk);
      end
      b_en = 1; @(posedge clk);
    end
    @(negedge clk); b_en = 0;
    wait_b(lat);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL gaps_latency: got %0d expected 6", lat); end
    n_checks++; if (b_dout !== 23'd226) begin n_fail++; $display("FAIL gaps_d_out: got %0d expected 226", $signed(b_dout)); end
    repeat (10) @(negedge clk);
    n_checks++; if (b_pulses - p0 !== 1) begin n_fail++; $display("FAIL gaps_pulses: got %0d expected 1", b_pulses - p0); end
  endtask

  task automatic test_clr();
    int lat, p0;
    n_checks++; if (b_dout !== 23'd226) begin n_fail++; $display("FAIL hold_d_out: got %0d expected 226", $signed(b_dout)); end
    b_data = {9{8'd7}}; b_w = {9{8'd7}}; b_bias = '0;
    p0 = b_pulses;
    // Two beats reach the accumulator, then a flush with a beat that must be dropped.
    b_en = 1; repeat (2) @(posedge clk); @(negedge clk); b_en = 0;
    repeat (8) @(negedge clk);
    b_clr = 1; b_en = 1; @(posedge clk); @(negedge clk);
    b_clr = 0;
    b_data = {9{8'd1}}; b_w = {9{8'd1}};
    repeat (4) @(posedge clk); @(negedge clk); b_en = 0;
    wait_b(lat);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL clr_latency: got %0d expected 6", lat); end
    n_checks++; if (b_dout !== 23'd36) begin n_fail++; $display("FAIL clr_d_out: got %0d expected 36", $signed(b_dout)); end
    repeat (10) @(negedge clk);
    n_checks++; if (b_pulses - p0 !== 1) begin n_fail++; $display("FAIL clr_pulses: got %0d expected 1", b_pulses - p0); end
  endtask

  task automatic test_rst_mid();
    int lat;
    c_data = 8'd5; c_w = 8'(-3); c_bias = '0;
    c_en = 1; repeat (2) @(posedge clk); @(negedge clk); c_en = 0;
    wait_c(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL k1_latency: got %0d expected 2", lat); end
    n_checks++; if (c_dout !== 18'(C_EXP)) begin n_fail++; $display("FAIL k1_d_out: got %0d expected %0d", $signed(c_dout), C_EXP); end
    repeat (3) @(negedge clk);
    // Half a pixel, then an asynchronous reset between edges.
    c_en = 1; @(posedge clk); @(negedge clk); c_en = 0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (c_eo !== 1'b0) begin n_fail++; $display("FAIL rst_mid_en_out: got %b expected 0", c_eo); end
    n_checks++; if (c_dout !== 18'd0) begin n_fail++; $display("FAIL rst_mid_c_d_out: got %0d expected 0", $signed(c_dout)); end
    n_checks++; if (b_dout !== 23'd0) begin n_fail++; $display("FAIL rst_mid_b_d_out: got %0d expected 0", $signed(b_dout)); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    c_en = 1; repeat (2) @(posedge clk); @(negedge clk); c_en = 0;
    wait_c(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 2", lat); end
    n_checks++; if (c_dout !== 18'(C_EXP)) begin n_fail++; $display("FAIL post_rst_d_out: got %0d expected %0d", $signed(c_dout), C_EXP); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_neg();
    test_signed_extreme();
    test_gaps();
    test_clr();
    test_rst_mid();
    n_checks++; if (b_b2b !== 0) begin n_fail++; $display("FAIL b_consecutive_en_out: got %0d expected 0", b_b2b); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
